// File: rtl/xb_oport.sv
// Crossbar output-port stage: registers one flit stream onto the link, tags its VC, tracks per-VC credits.
// Latency: 1 cycle from accepted flit to data_out/valid_out/vc_out; credit_avail/vc_empty follow counters.
// Backpressure: none upstream; flits without credit or with bad VC select are dropped and flag credit_err.
module xb_oport #(
  parameter int DW      = 32,
  parameter int V       = 4,
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_in,
  input  logic          valid_in,
  input  logic [V-1:0]  vc_sel,
  input  logic [V-1:0]  credit_in,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic [V-1:0]  vc_out,
  output logic [V-1:0]  credit_avail,
  output logic [V-1:0]  vc_empty,
  output logic          credit_err
);

  localparam logic [CW-1:0] CMAX = CW'(CREDITS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [V-1:0][CW-1:0] cnt;
  logic [V-1:0][CW-1:0] cnt_nxt;
  logic                 sel_ok;
  logic [V-1:0]         acc;
  logic                 acc_any;
  logic                 err_now;

  // Decide acceptance per VC and detect protocol errors this cycle.
  // A same-cycle credit return lets a flit through on an empty VC.
  always_comb begin
    sel_ok  = valid_in && $onehot(vc_sel);
    acc     = '0;
    err_now = valid_in && !$onehot(vc_sel);
    for (int i = 0; i < V; i++) begin
      if (sel_ok && vc_sel[i]) begin
        if (cnt[i] != '0 || credit_in[i]) begin
          acc[i] = 1'b1;
        end else begin
          err_now = 1'b1;
        end
      end
      if (credit_in[i] && cnt[i] == CMAX && !acc[i]) begin
        err_now = 1'b1;
      end
    end
    acc_any = |acc;
  end

  // Next counter values: accept and credit cancel; overflow saturates at CREDITS.
  always_comb begin
    for (int i = 0; i < V; i++) begin
      cnt_nxt[i] = cnt[i];
      if (acc[i] && !credit_in[i]) begin
        cnt_nxt[i] = cnt[i] - ONE;
      end else if (credit_in[i] && !acc[i] && cnt[i] != CMAX) begin
        cnt_nxt[i] = cnt[i] + ONE;
      end
    end
  end

  // Credit counters and the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= {V{CMAX}};
      credit_err <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      credit_err <= credit_err | err_now;
    end
  end

  // Link output register; data holds when nothing is forwarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      vc_out    <= '0;
    end else begin
      valid_out <= acc_any;
      vc_out    <= acc_any ? vc_sel : '0;
      if (acc_any) begin
        data_out <= data_in;
      end
    end
  end

  // Allocator-facing status decoded from the registered counters.
  always_comb begin
    for (int i = 0; i < V; i++) begin
      credit_avail[i] = (cnt[i] != '0);
      vc_empty[i]     = (cnt[i] == CMAX);
    end
  end

endmodule

// File: tb/tb_xb_oport.sv
// Testbench for xb_oport: directed scenarios plus random traffic against a queue-free counter model.
// Model state advances 1 ns after each rising edge; outputs are compared on every falling edge.
// Directed checks pin the model with hand-computed literal values.
module tb_xb_oport;

  localparam int DW = 32;
  localparam int V  = 4;
  localparam int CR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic [V-1:0]  vc_sel = '0;
  logic [V-1:0]  credit_in = '0;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [V-1:0]  vc_out;
  logic [V-1:0]  credit_avail;
  logic [V-1:0]  vc_empty;
  logic          credit_err;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the outputs must be right now.
  int            m_cnt [V];
  logic          m_err;
  logic          m_valid;
  logic [V-1:0]  m_vc;
  logic [DW-1:0] m_data;

  xb_oport #(.DW(DW), .V(V), .CREDITS(CR), .CW(3)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .vc_sel(vc_sel), .credit_in(credit_in), .data_out(data_out),
    .valid_out(valid_out), .vc_out(vc_out), .credit_avail(credit_avail),
    .vc_empty(vc_empty), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < V; i++) m_cnt[i] = CR;
    m_err   = 1'b0;
    m_valid = 1'b0;
    m_vc    = '0;
    m_data  = '0;
  endtask

  // Apply one cycle of stimulus and advance the model by the rules of the port.
  task automatic step(input logic v, input logic [V-1:0] sel, input logic [DW-1:0] d,
                      input logic [V-1:0] cr);
    int   n_cnt [V];
    int   vc;
    logic acc;
    logic nerr;
    valid_in  = v;
    vc_sel    = sel;
    data_in   = d;
    credit_in = cr;
    vc   = -1;
    for (int i = 0; i < V; i++) if (sel[i]) vc = i;
    acc  = 1'b0;
    nerr = 1'b0;
    if (v && $countones(sel) == 1) acc = (m_cnt[vc] > 0) || cr[vc];
    if (v && !acc) nerr = 1'b1;
    for (int i = 0; i < V; i++) begin
      n_cnt[i] = m_cnt[i];
      if (acc && i == vc && !cr[i]) n_cnt[i] = m_cnt[i] - 1;
      else if (cr[i] && !(acc && i == vc)) begin
        if (m_cnt[i] == CR) nerr = 1'b1;
        else n_cnt[i] = m_cnt[i] + 1;
      end
    end
    @(posedge clk);
    #1;
    m_valid = acc;
    m_vc    = acc ? sel : '0;
    if (acc) m_data = d;
    for (int i = 0; i < V; i++) m_cnt[i] = n_cnt[i];
    m_err = m_err | nerr;
  endtask

  task automatic do_reset();
    valid_in  = 1'b0;
    credit_in = '0;
    vc_sel    = '0;
    rst       = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Every cycle: all outputs against the model.
  always @(negedge clk) begin
    logic [V-1:0] e_avail;
    logic [V-1:0] e_empty;
    for (int i = 0; i < V; i++) begin
      e_avail[i] = (m_cnt[i] != 0);
      e_empty[i] = (m_cnt[i] == CR);
    end
    chk("cyc_valid_out", 64'(valid_out), 64'(m_valid));
    chk("cyc_vc_out", 64'(vc_out), 64'(m_vc));
    chk("cyc_data_out", 64'(data_out), 64'(m_data));
    chk("cyc_credit_avail", 64'(credit_avail), 64'(e_avail));
    chk("cyc_vc_empty", 64'(vc_empty), 64'(e_empty));
    chk("cyc_credit_err", 64'(credit_err), 64'(m_err));
  end

  initial begin
    logic [V-1:0] sel;
    logic [V-1:0] cr;
    model_reset();
    #1;
    do_reset();

    // Reset state
    chk("rst_avail", 64'(credit_avail), 64'h0F);
    chk("rst_empty", 64'(vc_empty), 64'h0F);
    chk("rst_valid", 64'(valid_out), 64'h0);
    chk("rst_err", 64'(credit_err), 64'h0);

    // Single flit on VC1
    step(1'b1, 4'b0010, 32'hA5A5_0001, 4'b0000);
    chk("fwd_valid", 64'(valid_out), 64'h1);
    chk("fwd_data", 64'(data_out), 64'hA5A5_0001);
    chk("fwd_vc", 64'(vc_out), 64'h2);
    chk("fwd_empty", 64'(vc_empty), 64'hD);
    step(1'b0, 4'b0000, 32'h0, 4'b0000);
    chk("idle_valid", 64'(valid_out), 64'h0);
    chk("idle_data_hold", 64'(data_out), 64'hA5A5_0001);

    // Empty VC0 accepts a flit when a credit returns in the same cycle
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 4'b0001, 32'h100 + k, 4'b0000);
    chk("vc0_drained", 64'(credit_avail), 64'hE);
    step(1'b1, 4'b0001, 32'hC0DE_0000, 4'b0001);
    chk("bypass_valid", 64'(valid_out), 64'h1);
    chk("bypass_data", 64'(data_out), 64'hC0DE_0000);
    chk("bypass_avail", 64'(credit_avail), 64'hE);
    chk("bypass_err", 64'(credit_err), 64'h0);

    // Exhaust VC2, overrun, then return one credit
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 4'b0100, 32'h200 + k, 4'b0000);
    chk("vc2_exhaust", 64'(credit_avail), 64'hB);
    step(1'b1, 4'b0100, 32'h2FF, 4'b0000);
    chk("overrun_valid", 64'(valid_out), 64'h0);
    chk("overrun_err", 64'(credit_err), 64'h1);
    step(1'b0, 4'b0000, 32'h0, 4'b0100);
    chk("vc2_credit_back", 64'(credit_avail), 64'hF);

    // Credit overflow saturates
    do_reset();
    step(1'b0, 4'b0000, 32'h0, 4'b1000);
    chk("ovf_err", 64'(credit_err), 64'h1);
    chk("ovf_empty", 64'(vc_empty), 64'hF);

    // Multi-hot select is dropped
    do_reset();
    step(1'b1, 4'b0110, 32'hBAD0_0000, 4'b0000);
    chk("mhot_valid", 64'(valid_out), 64'h0);
    chk("mhot_err", 64'(credit_err), 64'h1);
    chk("mhot_empty", 64'(vc_empty), 64'hF);

    // Random traffic with occasional resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      if ($urandom_range(0, 9) < 8) sel = 4'(1 << $urandom_range(0, 3));
      else sel = 4'($urandom_range(0, 15));
      for (int i = 0; i < V; i++) cr[i] = ($urandom_range(0, 9) < 3);
      step(($urandom_range(0, 9) < 7), sel, $urandom, cr);
    end

    // Async reset mid-stream with counts {1,2,0,3}
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 4'b0001, 32'h300 + k, 4'b0000);
    for (int k = 0; k < 2; k++) step(1'b1, 4'b0010, 32'h310 + k, 4'b0000);
    step(1'b1, 4'b1000, 32'h320, 4'b0000);
    for (int k = 0; k < 4; k++) step(1'b1, 4'b0100, 32'h330 + k, 4'b0000);
    valid_in = 1'b0;
    chk("pre_rst_avail", 64'(credit_avail), 64'hB);
    chk("pre_rst_empty", 64'(vc_empty), 64'h0);
    chk("pre_rst_valid", 64'(valid_out), 64'h1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_valid", 64'(valid_out), 64'h0);
    chk("async_vc", 64'(vc_out), 64'h0);
    chk("async_data", 64'(data_out), 64'h0);
    chk("async_avail", 64'(credit_avail), 64'hF);
    chk("async_empty", 64'(vc_empty), 64'hF);
    // Credits are ignored while reset is held
    credit_in = 4'b1111;
    @(posedge clk);
    #1;
    chk("rst_credit_ignored", 64'(credit_err), 64'h0);
    credit_in = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 4'b0000, 32'h0, 4'b0000);
    step(1'b0, 4'b0000, 32'h0, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
